// File: rtl/soc_system_onchip_mem_packer.sv
// Packs a 32-bit valid/ready stream into 128-bit RAM lines, one write per line.
// Each line starts at address 0 for a new transfer; the RAM filling up before s_last raises a sticky overflow flag.
module soc_system_onchip_mem_packer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [127:0]      mem_writedata,
    output logic [15:0]       mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   lines_written
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [1:0]          r_lane;
    logic                r_last_line;
    logic                r_s_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic [127:0]        r_wdata;
    logic [15:0]         r_be;
    logic                r_cs;
    logic                r_write;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;
    logic [ADDR_W:0]     r_lines;

    logic                w_accept;
    logic                w_line_end;
    logic [15:0]         w_be_line;

    assign w_accept   = (r_state == FILL) && s_valid && r_s_ready;
    assign w_line_end = w_accept && ((r_lane == 2'd3) || s_last);

    // Byte lanes covered once the word in the current lane lands.
    always_comb begin
        w_be_line = 16'h0000;
        case (r_lane)
            2'd0:    w_be_line = 16'h000F;
            2'd1:    w_be_line = 16'h00FF;
            2'd2:    w_be_line = 16'h0FFF;
            default: w_be_line = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lane      <= 2'd0;
            r_last_line <= 1'b0;
            r_s_ready   <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_cs        <= 1'b0;
            r_write     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_lines     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FILL;
                        r_s_ready   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_lane      <= 2'd0;
                        r_addr      <= '0;
                        r_lines     <= '0;
                        r_overflow  <= 1'b0;
                        r_wdata     <= '0;
                        r_last_line <= 1'b0;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        r_wdata[{r_lane, 5'b00000} +: 32] <= s_data;
                        r_lane <= 2'(r_lane + 2'd1);
                    end
                    if (w_line_end) begin
                        r_state     <= WRITE;
                        r_s_ready   <= 1'b0;
                        r_cs        <= 1'b1;
                        r_write     <= 1'b1;
                        r_be        <= w_be_line;
                        r_last_line <= s_last;
                    end
                end
                WRITE: begin
                    r_cs    <= 1'b0;
                    r_write <= 1'b0;
                    r_be    <= '0;
                    r_lane  <= 2'd0;
                    r_wdata <= '0;
                    r_lines <= (ADDR_W+1)'(r_lines + 1'b1);
                    if (r_last_line) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (r_addr == LAST_ADDR) begin
                        // RAM full without s_last: stop rather than wrap to line 0.
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_overflow <= 1'b1;
                    end else begin
                        r_addr    <= ADDR_W'(r_addr + 1'b1);
                        r_state   <= FILL;
                        r_s_ready <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready        = r_s_ready;
    assign mem_address    = r_addr;
    assign mem_writedata  = r_wdata;
    assign mem_byteenable = r_be;
    assign mem_chipselect = r_cs;
    assign mem_write      = r_write;
    assign mem_clken      = ~reset;
    assign busy           = r_busy;
    assign done           = r_done;
    assign overflow       = r_overflow;
    assign lines_written  = r_lines;

endmodule

// File: tb/tb_soc_system_onchip_mem_packer.sv
// Self-checking bench: table of transfers, scoreboard of expected RAM writes, plus reset corner sequences.
module tb_soc_system_onchip_mem_packer;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [127:0]      mem_writedata;
    logic [15:0]       mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic              mem_clken;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   lines_written;

    soc_system_onchip_mem_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken),
        .busy(busy), .done(done), .overflow(overflow), .lines_written(lines_written)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [127:0]      data;
        logic [15:0]       be;
    } wr_t;

    typedef struct {
        int n;
        bit with_last;
        int pct;
        bit glitch;
        int exp_lines;
        bit exp_ovf;
    } vec_t;

    wr_t          exp_q[$];
    vec_t         vecs[7];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [127:0] last_wdata = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] out_flags();
        return 128'({s_ready, |mem_address, |mem_writedata, |mem_byteenable,
                     mem_chipselect, mem_write, busy, done, overflow, |lines_written});
    endfunction

    // Every RAM write must match the head of the scoreboard; no strobe outside WRITE.
    always @(negedge clk) begin
        wr_t e;
        if (mem_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_address, mem_writedata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 128'(mem_address), 128'(e.addr));
                chk("wr_data", mem_writedata, e.data);
                chk("wr_be", 128'(mem_byteenable), 128'(e.be));
                chk("wr_cs", 128'(mem_chipselect), 128'(1));
            end
            last_wdata = mem_writedata;
        end else begin
            chk("idle_cs_be", 128'({mem_chipselect, mem_byteenable}), 128'(0));
        end
    end

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Streams n words with random valid gaps; returns at the negedge after the last accept edge.
    task automatic send_words(input int v, input int n, input bit with_last, input int pct, input bit glitch);
        int           i = 0;
        int           cyc = 0;
        bit           g = glitch;
        bit           vld;
        bit           lst;
        logic [31:0]  w;
        logic [127:0] lbuf = '0;
        logic [15:0]  lbe = '0;
        wr_t          e;
        while (i < n && cyc < 2000) begin
            @(negedge clk);
            start = g && (i == 2);
            if (start) g = 1'b0;
            vld = ($urandom_range(99) < pct);
            w   = (32'(v) << 24) | 32'(i);
            lst = with_last && (i == n - 1);
            s_valid = vld;
            s_data  = w;
            s_last  = vld ? lst : 1'($urandom_range(1));
            if (vld && s_ready) begin
                lbuf[32*(i%4) +: 32] = w;
                lbe[4*(i%4) +: 4]    = 4'hF;
                if ((i % 4 == 3) || lst) begin
                    e.addr = ADDR_W'(i / 4);
                    e.data = lbuf;
                    e.be   = lbe;
                    exp_q.push_back(e);
                    lbuf = '0;
                    lbe  = '0;
                end
                i++;
            end
            cyc++;
        end
        chk("stream_accepted", 128'(i), 128'(n));
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic finish_check(input int exp_lines, input bit exp_ovf);
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 128'(done), 128'(1));
        chk("lines_written", 128'(lines_written), 128'(exp_lines));
        chk("overflow", 128'(overflow), 128'(exp_ovf));
        chk("ready_busy_in_done", 128'({s_ready, busy}), 128'(2'b01));
        @(negedge clk);
        chk("done_pulse_end", 128'({done, busy, s_ready}), 128'(0));
        chk("lines_hold", 128'(lines_written), 128'(exp_lines));
        chk("overflow_hold", 128'(overflow), 128'(exp_ovf));
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        vecs[0] = '{8,   1'b1, 100, 1'b0, 2,  1'b0};
        vecs[1] = '{5,   1'b1, 100, 1'b0, 2,  1'b0};
        vecs[2] = '{1,   1'b1, 100, 1'b0, 1,  1'b0};
        vecs[3] = '{4,   1'b1, 100, 1'b0, 1,  1'b0};
        vecs[4] = '{13,  1'b1, 50,  1'b0, 4,  1'b0};
        vecs[5] = '{256, 1'b0, 100, 1'b0, 64, 1'b1};
        vecs[6] = '{30,  1'b1, 40,  1'b1, 8,  1'b0};

        repeat (2) @(negedge clk);
        chk("reset_outputs", out_flags(), 128'(0));
        chk("clken_in_reset", 128'(mem_clken), 128'(0));
        reset = 1'b0;
        #1;
        chk("clken_after_reset", 128'(mem_clken), 128'(1));

        for (int v = 0; v < 7; v++) begin
            do_start();
            send_words(v, vecs[v].n, vecs[v].with_last, vecs[v].pct, vecs[v].glitch);
            finish_check(vecs[v].exp_lines, vecs[v].exp_ovf);
            if (v == 0)
                chk("line1_packed", last_wdata, 128'h00000007_00000006_00000005_00000004);
        end

        // Reset two words into a line: nothing written, next transfer restarts at line 0.
        do_start();
        send_words(9, 2, 1'b0, 100, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_fill", out_flags(), 128'(0));
        chk("clken_mid_reset", 128'(mem_clken), 128'(0));
        reset = 1'b0;
        do_start();
        send_words(10, 4, 1'b1, 100, 1'b0);
        finish_check(1, 1'b0);

        // Reset during the WRITE cycle: strobe drops the following cycle.
        do_start();
        send_words(11, 4, 1'b0, 100, 1'b0);
        chk("write_strobe", 128'(mem_write), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("reset_in_write", out_flags(), 128'(0));
        reset = 1'b0;
        @(negedge clk);
        chk("queue_after_reset", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/soc_system_onchip_mem_packer.md
SOC_SYSTEM_ONCHIP_MEM_PACKER -- requirements
Module: soc_system_onchip_mem_packer

Interface
REQ-001 Parameter DEPTH, default 64: number of 128-bit lines in the target RAM port.
REQ-002 Parameter ADDR_W, default 6: line address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 start  in  1  one-cycle pulse that begins a fill at line 0; ignored unless in IDLE.
REQ-006 s_data  in  32  stream word.
REQ-007 s_valid  in  1  s_data is valid.
REQ-008 s_last  in  1  marks the final word of the transfer; qualified by s_valid.
REQ-009 s_ready  out  1  packer accepts a word this cycle.
REQ-010 mem_address  out  ADDR_W  RAM line address (drives address2).
REQ-011 mem_writedata  out  128  packed line (drives writedata2).
REQ-012 mem_byteenable  out  16  byte lanes written (drives byteenable2).
REQ-013 mem_chipselect  out  1  RAM port select (drives chipselect2).
REQ-014 mem_write  out  1  RAM write strobe (drives write2).
REQ-015 mem_clken  out  1  RAM clock enable (drives clken2); constant 1 outside reset.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse at end of transfer.
REQ-018 overflow  out  1  sticky: RAM filled before s_last; cleared by next accepted start.
REQ-019 lines_written  out  ADDR_W+1  lines written in current/last transfer, range 0..DEPTH.

Function
REQ-020 FSM states SHALL be IDLE, FILL, WRITE, DONE.
REQ-021 IDLE: s_ready=0, mem_write=0; start=1 -> FILL, lane=0, line address=0, lines_written=0, overflow=0, mem_writedata=0.
REQ-022 FILL: s_ready=1; a word is accepted iff s_valid&s_ready at a rising edge.
REQ-023 Accepted word SHALL be stored in lane k bits [32k+31:32k], k = lane counter 0..3 (lane 0 = least significant bytes); lane counter then increments.
REQ-024 FILL -> WRITE after accepting lane 3 or after accepting any word with s_last=1.
REQ-025 WRITE lasts exactly one cycle: mem_chipselect=1, mem_write=1, s_ready=0, mem_address=current line.
REQ-026 mem_byteenable in WRITE SHALL be 4'hF per filled lane, zero for unfilled lanes (full line = 16'hFFFF; one word = 16'h000F).
REQ-027 Unfilled lanes of mem_writedata SHALL be 0.
REQ-028 On leaving WRITE: lines_written += 1; lane counter and mem_writedata cleared.
REQ-029 WRITE -> DONE if the line held s_last; WRITE -> DONE with overflow=1 if line address was DEPTH-1 without s_last; else line address += 1 and -> FILL.
REQ-030 Line address SHALL never wrap to 0 within one transfer.
REQ-031 DONE: done=1 for exactly one cycle, s_ready=0, then -> IDLE.
REQ-032 mem_chipselect and mem_write SHALL be 0 in every state except WRITE; byteenable 0 when not writing.
REQ-033 lines_written and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-034 s_last asserted with s_valid=0 SHALL have no effect.
REQ-035 start asserted in FILL/WRITE/DONE SHALL be ignored, no state change.
REQ-036 Latency: word accepted at edge N completing a line -> mem_write high during cycle N+1 (one edge later in WRITE).

Reset
REQ-037 reset=1 at an edge SHALL force IDLE and zero: s_ready, mem_address, mem_writedata, mem_byteenable, mem_chipselect, mem_write, busy, done, overflow, lines_written, lane counter.
REQ-038 mem_clken SHALL be 0 while reset=1, 1 otherwise.
REQ-039 reset during WRITE SHALL suppress the write strobe from the following cycle; partially filled line is discarded.
REQ-040 reset has priority over start and any stream handshake in the same cycle.

Verification
REQ-041 start, 8 words 0x0..0x7 with s_last on 8th -> line0=0x00000003_00000002_00000001_00000000, line1=0x7_6_5_4 packed, byteenable 16'hFFFF both, done pulse, lines_written=2, overflow=0.
REQ-042 start, 5 words with s_last on 5th -> line1 written with byteenable 16'h000F, upper 96 bits 0, lines_written=2.
REQ-043 start, 256 words with no s_last -> 64 writes addresses 0..63, overflow=1, lines_written=64, s_ready=0 after final write, no write to address 0 again.
REQ-044 s_valid toggled randomly during FILL -> only handshaked words packed, order preserved, mem_write exactly once per line.
REQ-045 reset asserted mid-FILL after 2 words -> all outputs 0 next cycle, no write issued; subsequent start writes from address 0.
REQ-046 start pulsed while busy -> ignored; lines_written and addresses unaffected.
